// File: rtl/seed_tree_sched.sv
// Seed-tree expander: grows a binary tree of 128-bit seeds from a root via a shared tagged H pool, then streams the leaves in index order.
// Latency: first H request one cycle after an accepted start; children issuable the cycle after their parent's digest lands.
// Backpressure: requests wait on hash_req_ready with msg/tag held stable; leaves wait on leaf_ready with seed/idx held stable.
//
// Ports:
//   clk, reset (async, active-low)
//   start, root_seed, salt, t      - run request; sampled only when IDLE
//   busy                           - high whenever not IDLE
//   hash_req_valid/ready/msg/tag   - H request to the pool (tag = node being expanded)
//   hash_rsp_valid/digest/tag      - H response, always accepted, may arrive out of order
//   leaf_valid/ready/seed/idx      - leaf seed stream, idx 0..2^DEPTH-1
//   tree_done                      - one-cycle pulse after the last leaf handshake
//
// Optional build macro SEED_TREE_PERF_EN adds perf_stall_cycles[15:0]: saturating count of
// EXPAND cycles where the current node is issuable but no request is accepted.

module seed_tree_sched #(
    parameter int DEPTH   = 6,
    parameter int MAX_OUT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] root_seed,
    input  logic [255:0] salt,
    input  logic [7:0]   t,
    output logic         busy,
    output logic         hash_req_valid,
    input  logic         hash_req_ready,
    output logic [511:0] hash_req_msg,
    output logic [7:0]   hash_req_tag,
    input  logic         hash_rsp_valid,
    input  logic [255:0] hash_rsp_digest,
    input  logic [7:0]   hash_rsp_tag,
    output logic         leaf_valid,
    input  logic         leaf_ready,
    output logic [127:0] leaf_seed,
    output logic [7:0]   leaf_idx,
    output logic         tree_done
`ifdef SEED_TREE_PERF_EN
    ,
    output logic [15:0]  perf_stall_cycles
`endif
);

    localparam int NLEAF = 1 << DEPTH;
    localparam int NINT  = NLEAF - 1;
    localparam int NNODE = 2 * NLEAF - 1;
    localparam logic [DEPTH:0] LEAF_BASE = (DEPTH+1)'(NINT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_STREAM,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    // ip only ever needs to reach NINT (all ones), which marks "every internal node issued"
    logic [DEPTH-1:0]   ip_q, ip_d;
    logic [4:0]         out_q, out_d;
    logic [DEPTH-1:0]   leaf_cnt_q, leaf_cnt_d;
    logic [NNODE-1:0]   have_q;
    // One pending bit per internal node; the top bit is never set and only pads the index width
    logic [NLEAF-1:0]   pend_q;
    logic [127:0]       seed_q [NNODE];
    logic [255:0]       salt_q;
    logic [7:0]         t_q;

    logic               start_acc;
    logic               ip_live;
    logic               issue_ok;
    logic               issue;
    logic               rsp_ok;
    logic [DEPTH-1:0]   rsp_idx;
    logic [DEPTH:0]     child_a;
    logic [DEPTH:0]     child_b;
    logic [DEPTH:0]     leaf_node;

    assign start_acc = (state_q == S_IDLE) && start;
    assign ip_live   = (state_q == S_EXPAND) && (ip_q != {DEPTH{1'b1}});
    assign issue_ok  = ip_live && have_q[{1'b0, ip_q}] && (out_q < 5'(MAX_OUT));
    assign issue     = issue_ok && hash_req_ready;

    // Only tags with a live request count; stale responses after a reset or stray tags are dropped
    assign rsp_idx   = hash_rsp_tag[DEPTH-1:0];
    assign rsp_ok    = (state_q == S_EXPAND) && hash_rsp_valid &&
                       (int'(hash_rsp_tag) < NINT) && pend_q[rsp_idx];
    assign child_a   = {rsp_idx, 1'b1};
    assign child_b   = child_a + 1'b1;
    assign leaf_node = LEAF_BASE + {1'b0, leaf_cnt_q};

    // Request payload is a pure function of ip and stored seeds, so it cannot move until the handshake
    assign hash_req_valid = issue_ok;
    assign hash_req_tag   = ip_live ? 8'(ip_q) : 8'h00;
    assign hash_req_msg   = ip_live ? {8'h01, seed_q[{1'b0, ip_q}], salt_q, t_q, 8'(ip_q),
                                       8'h80, 32'h0, 64'h198} : 512'h0;

    assign busy      = (state_q != S_IDLE);
    assign leaf_seed = leaf_valid ? seed_q[leaf_node] : 128'h0;
    assign leaf_idx  = leaf_valid ? 8'(leaf_cnt_q) : 8'h00;

    always_comb begin
        state_d    = state_q;
        ip_d       = ip_q;
        out_d      = out_q;
        leaf_cnt_d = leaf_cnt_q;
        leaf_valid = 1'b0;
        tree_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_EXPAND;
                    ip_d       = '0;
                    out_d      = '0;
                    leaf_cnt_d = '0;
                end
            end
            S_EXPAND: begin
                if (issue) begin
                    ip_d = ip_q + 1'b1;
                end
                out_d = out_q + {4'b0, issue} - {4'b0, rsp_ok};
                if (!ip_live && (out_q == 5'd0)) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                leaf_valid = 1'b1;
                if (leaf_ready) begin
                    if (leaf_cnt_q == {DEPTH{1'b1}}) begin
                        state_d = S_DONE;
                    end else begin
                        leaf_cnt_d = leaf_cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                tree_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ip_q       <= '0;
            out_q      <= '0;
            leaf_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ip_q       <= ip_d;
            out_q      <= out_d;
            leaf_cnt_q <= leaf_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            have_q <= '0;
            pend_q <= '0;
        end else if (start_acc) begin
            have_q <= NNODE'(1);
            pend_q <= '0;
        end else begin
            if (issue) begin
                pend_q[ip_q] <= 1'b1;
            end
            if (rsp_ok) begin
                pend_q[rsp_idx]  <= 1'b0;
                have_q[child_a]  <= 1'b1;
                have_q[child_b]  <= 1'b1;
            end
        end
    end

    // Seed storage is qualified by have_q, so it carries no reset
    always_ff @(posedge clk) begin
        if (start_acc) begin
            seed_q[0] <= root_seed;
            salt_q    <= salt;
            t_q       <= t;
        end
        if (rsp_ok) begin
            seed_q[child_a] <= hash_rsp_digest[255:128];
            seed_q[child_b] <= hash_rsp_digest[127:0];
        end
    end

`ifdef SEED_TREE_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (start_acc) begin
            perf_q <= '0;
        end else if (ip_live && have_q[{1'b0, ip_q}] && !issue && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_stall_cycles = perf_q;
`endif

endmodule

// File: tb/tb_seed_tree_sched.sv
module tb_seed_tree_sched;

    localparam int D  = 6;
    localparam int MO = 4;
    localparam int NL = 1 << D;
    localparam int NI = NL - 1;
    localparam int NN = 2 * NL - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] root_seed;
    logic [255:0] salt;
    logic [7:0]   t;
    logic         busy;
    logic         hash_req_valid;
    logic         hash_req_ready;
    logic [511:0] hash_req_msg;
    logic [7:0]   hash_req_tag;
    logic         hash_rsp_valid;
    logic [255:0] hash_rsp_digest;
    logic [7:0]   hash_rsp_tag;
    logic         leaf_valid;
    logic         leaf_ready;
    logic [127:0] leaf_seed;
    logic [7:0]   leaf_idx;
    logic         tree_done;

    logic         d1_start;
    logic [127:0] d1_root;
    logic [255:0] d1_salt;
    logic [7:0]   d1_t;
    logic         d1_busy;
    logic         d1_req_valid;
    logic         d1_req_ready;
    logic [511:0] d1_req_msg;
    logic [7:0]   d1_req_tag;
    logic         d1_rsp_valid;
    logic [255:0] d1_rsp_digest;
    logic [7:0]   d1_rsp_tag;
    logic         d1_leaf_valid;
    logic         d1_leaf_ready;
    logic [127:0] d1_leaf_seed;
    logic [7:0]   d1_leaf_idx;
    logic         d1_done;
`ifdef SEED_TREE_PERF_EN
    logic [15:0]  perf0;
    logic [15:0]  perf1;
`endif

    always #5 clk = ~clk;

    seed_tree_sched #(.DEPTH(D), .MAX_OUT(MO)) u_dut (
        .clk(clk), .reset(reset), .start(start), .root_seed(root_seed), .salt(salt), .t(t),
        .busy(busy), .hash_req_valid(hash_req_valid), .hash_req_ready(hash_req_ready),
        .hash_req_msg(hash_req_msg), .hash_req_tag(hash_req_tag),
        .hash_rsp_valid(hash_rsp_valid), .hash_rsp_digest(hash_rsp_digest), .hash_rsp_tag(hash_rsp_tag),
        .leaf_valid(leaf_valid), .leaf_ready(leaf_ready), .leaf_seed(leaf_seed), .leaf_idx(leaf_idx),
        .tree_done(tree_done)
`ifdef SEED_TREE_PERF_EN
        , .perf_stall_cycles(perf0)
`endif
    );

    seed_tree_sched #(.DEPTH(1), .MAX_OUT(1)) u_dut_d1 (
        .clk(clk), .reset(reset), .start(d1_start), .root_seed(d1_root), .salt(d1_salt), .t(d1_t),
        .busy(d1_busy), .hash_req_valid(d1_req_valid), .hash_req_ready(d1_req_ready),
        .hash_req_msg(d1_req_msg), .hash_req_tag(d1_req_tag),
        .hash_rsp_valid(d1_rsp_valid), .hash_rsp_digest(d1_rsp_digest), .hash_rsp_tag(d1_rsp_tag),
        .leaf_valid(d1_leaf_valid), .leaf_ready(d1_leaf_ready), .leaf_seed(d1_leaf_seed), .leaf_idx(d1_leaf_idx),
        .tree_done(d1_done)
`ifdef SEED_TREE_PERF_EN
        , .perf_stall_cycles(perf1)
`endif
    );

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    task automatic check_vec(input string tag, input logic [511:0] got, input logic [511:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference H used by the bench responder and the software tree model
    function automatic logic [255:0] hfn(input logic [127:0] s, input logic [7:0] n, input logic [7:0] tt);
        logic [127:0] hi;
        logic [127:0] lo;
        hi = s ^ {16{n}} ^ 128'h5a5a0f0f3c3c9696a5a5f0f0c3c36969;
        lo = {s[63:0], s[127:64]} + {112'd0, tt, n};
        return {hi, lo};
    endfunction

    logic [127:0] model [NN];
    logic [255:0] cur_salt;
    logic [7:0]   cur_t;
    int           q_tag [$];
    int           q_due [$];
    logic [127:0] q_seed [$];
    int           cyc = 0;
    int           inflight = 0;
    int           max_inflight = 0;
    int           exp_ip = 0;
    int           exp_leaf = 0;
    int           issued = 0;
    int           done_cnt = 0;
    bit           en_rsp = 1'b1;
    bit           toggle_leaf = 1'b0;
    bit           stall_arm = 1'b0;
    bit           hold_active = 1'b0;
    int           hold_cnt = 0;
    logic [511:0] hold_msg;
    logic [7:0]   hold_tag;
    logic [15:0]  hold_perf;
    bit           leaf_held = 1'b0;
    logic [127:0] held_seed;
    logic [7:0]   held_idx;

    task automatic build_model(input logic [127:0] root, input logic [7:0] tt);
        logic [255:0] dg;
        model[0] = root;
        for (int n = 0; n < NI; n++) begin
            dg = hfn(model[n], 8'(n), tt);
            model[2*n+1] = dg[255:128];
            model[2*n+2] = dg[127:0];
        end
    endtask

    // One cycle of the bench-side pool and leaf consumer; inputs change at the negedge
    task automatic tick();
        @(negedge clk);
        if (hold_active) begin
            check_vec("stall_msg_stable", hash_req_msg, hold_msg);
            check_vec("stall_tag_stable", hash_req_tag, hold_tag);
            if (hold_cnt == 0) begin
`ifdef SEED_TREE_PERF_EN
                check_vec("perf_stall_10", perf0 - hold_perf, 16'd10);
`endif
                hold_active = 1'b0;
            end
        end
        if (stall_arm && !hold_active && hash_req_valid && issued >= 5) begin
            hold_msg    = hash_req_msg;
            hold_tag    = hash_req_tag;
`ifdef SEED_TREE_PERF_EN
            hold_perf   = perf0;
`else
            hold_perf   = 16'd0;
`endif
            hold_cnt    = 10;
            hold_active = 1'b1;
            stall_arm   = 1'b0;
        end
        hash_req_ready = !(hold_active && hold_cnt > 0);
        if (hold_active && hold_cnt > 0) hold_cnt--;

        if (hash_req_valid && hash_req_ready) begin
            check_vec("req_order", hash_req_tag, exp_ip);
            check_vec("req_msg", hash_req_msg,
                      {8'h01, model[exp_ip], cur_salt, cur_t, 8'(exp_ip), 8'h80, 32'h0, 64'h198});
            q_tag.push_back(int'(hash_req_tag));
            q_seed.push_back(hash_req_msg[503:376]);
            q_due.push_back(cyc + int'($urandom_range(1, 20)));
            exp_ip++;
            issued++;
            inflight++;
            if (inflight > max_inflight) max_inflight = inflight;
        end

        hash_rsp_valid = 1'b0;
        if (en_rsp) begin
            for (int i = 0; i < q_tag.size(); i++) begin
                if (q_due[i] <= cyc) begin
                    hash_rsp_valid  = 1'b1;
                    hash_rsp_tag    = 8'(q_tag[i]);
                    hash_rsp_digest = hfn(q_seed[i], 8'(q_tag[i]), cur_t);
                    q_tag.delete(i);
                    q_seed.delete(i);
                    q_due.delete(i);
                    inflight--;
                    break;
                end
            end
        end

        leaf_ready = toggle_leaf ? ((cyc % 2) == 0) : 1'b1;
        if (leaf_held) begin
            check_vec("leaf_hold_idx", leaf_idx, held_idx);
            check_vec("leaf_hold_seed", leaf_seed, held_seed);
        end
        if (leaf_valid && leaf_ready) begin
            check_vec("leaf_idx", leaf_idx, exp_leaf);
            check_vec("leaf_seed", leaf_seed, model[NI + exp_leaf]);
            exp_leaf++;
        end
        leaf_held = leaf_valid && !leaf_ready;
        held_idx  = leaf_idx;
        held_seed = leaf_seed;
        if (tree_done) done_cnt++;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_vec({pfx, "_busy"}, busy, 1'b0);
        check_vec({pfx, "_req_valid"}, hash_req_valid, 1'b0);
        check_vec({pfx, "_req_msg"}, hash_req_msg, 512'h0);
        check_vec({pfx, "_req_tag"}, hash_req_tag, 8'h00);
        check_vec({pfx, "_leaf_valid"}, leaf_valid, 1'b0);
        check_vec({pfx, "_leaf_seed"}, leaf_seed, 128'h0);
        check_vec({pfx, "_leaf_idx"}, leaf_idx, 8'h00);
        check_vec({pfx, "_tree_done"}, tree_done, 1'b0);
    endtask

    task automatic run_tree(input logic [127:0] root, input logic [255:0] s, input logic [7:0] tt,
                            input bit tog, input bit stall, input bit poke, input bit abort);
        bit poked;
        build_model(root, tt);
        cur_salt = s;
        cur_t = tt;
        exp_ip = 0;
        exp_leaf = 0;
        issued = 0;
        done_cnt = 0;
        inflight = 0;
        max_inflight = 0;
        toggle_leaf = tog;
        stall_arm = stall;
        en_rsp = 1'b1;
        poked = 1'b0;
        root_seed = root;
        salt = s;
        t = tt;
        start = 1'b1;
        tick();
        start = 1'b0;
        root_seed = ~root;
        check_vec("busy_after_start", busy, 1'b1);
        check_vec("first_req_cycle1", hash_req_valid, 1'b1);
`ifdef SEED_TREE_PERF_EN
        check_vec("perf_clear_on_start", perf0, 16'd0);
`endif
        for (int k = 0; k < 6000 && done_cnt == 0; k++) begin
            tick();
            start = 1'b0;
            if (abort && inflight == 3) break;
            if (poke && !poked && leaf_valid && exp_leaf >= 5) begin
                start = 1'b1;
                poked = 1'b1;
            end
        end
        if (!abort) begin
            check_vec("done_pulse", done_cnt, 1);
            check_vec("leaf_count", exp_leaf, NL);
            check_vec("issue_count", issued, NI);
            check_vec("max_inflight_ok", max_inflight <= MO, 1'b1);
            tick();
            check_vec("idle_after_done", busy, 1'b0);
            check_vec("done_single", done_cnt, 1);
        end
    endtask

    int d1_reqs;
    int d1_leaves;
    int d1_done_cnt;
    bit d1_pend;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        root_seed = '0;
        salt = '0;
        t = '0;
        hash_req_ready = 1'b1;
        hash_rsp_valid = 1'b0;
        hash_rsp_digest = '0;
        hash_rsp_tag = '0;
        leaf_ready = 1'b1;
        d1_start = 1'b0;
        d1_root = '0;
        d1_salt = '0;
        d1_t = '0;
        d1_req_ready = 1'b1;
        d1_rsp_valid = 1'b0;
        d1_rsp_digest = '0;
        d1_rsp_tag = '0;
        d1_leaf_ready = 1'b1;

        tick();
        tick();
        check_reset_outputs("por");
        reset = 1'b1;
        tick();

        // Run with a 10-cycle ready-low burst in EXPAND
        run_tree(128'h00112233445566778899aabbccddeeff,
                 256'hfeedface_cafebabe_01234567_89abcdef_deadbeef_0badf00d_13579bdf_2468ace0,
                 8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
        // Leaf ready toggling plus a start pulse during STREAM
        run_tree(128'hffeeddccbbaa99887766554433221100,
                 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888,
                 8'h2a, 1'b1, 1'b0, 1'b1, 1'b0);

        // Mid-EXPAND reset with 3 requests in flight, late responses land in IDLE
        run_tree(128'h0f0f0f0f_f0f0f0f0_12345678_9abcdef0,
                 256'h0, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
        check_vec("abort_inflight3", inflight, 3);
        en_rsp = 1'b0;
        reset = 1'b0;
        tick();
        check_reset_outputs("midrun");
        reset = 1'b1;
        tick();
        en_rsp = 1'b1;
        for (int k = 0; k < 25; k++) tick();
        check_vec("stale_rsp_busy", busy, 1'b0);
        check_vec("stale_rsp_no_req", hash_req_valid, 1'b0);
        inflight = 0;
        run_tree(128'h13579bdf_02468ace_fdb97531_eca86420,
                 256'habcdef01_23456789_abcdef01_23456789_abcdef01_23456789_abcdef01_23456789,
                 8'hc3, 1'b0, 1'b0, 1'b0, 1'b0);

        // DEPTH=1 instance with a fixed echo digest
        d1_root = 128'h0123456789abcdef_fedcba9876543210;
        d1_salt = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
        d1_t = 8'h00;
        d1_start = 1'b1;
        d1_reqs = 0;
        d1_leaves = 0;
        d1_done_cnt = 0;
        d1_pend = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            d1_start = 1'b0;
            d1_rsp_valid = 1'b0;
            if (d1_pend) begin
                d1_rsp_valid  = 1'b1;
                d1_rsp_tag    = 8'h00;
                d1_rsp_digest = {{32{4'hA}}, {32{4'hB}}};
                d1_pend = 1'b0;
            end
            if (d1_req_valid) begin
                d1_reqs++;
                check_vec("d1_req_tag", d1_req_tag, 8'h00);
                check_vec("d1_req_msg", d1_req_msg,
                          {8'h01, 128'h0123456789abcdef_fedcba9876543210,
                           256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f,
                           8'h00, 8'h00, 8'h80, 32'h0, 64'h198});
                d1_pend = 1'b1;
            end
            if (d1_leaf_valid) begin
                check_vec("d1_leaf_idx", d1_leaf_idx, d1_leaves);
                check_vec("d1_leaf_seed", d1_leaf_seed, (d1_leaves == 0) ? {32{4'hA}} : {32{4'hB}});
                d1_leaves++;
            end
            if (d1_done) d1_done_cnt++;
        end
        check_vec("d1_req_count", d1_reqs, 1);
        check_vec("d1_leaf_count", d1_leaves, 2);
        check_vec("d1_done_count", d1_done_cnt, 1);
        check_vec("d1_idle", d1_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
